bin_bbox_overlay: RTL and testbench
===================================

# bin_bbox_overlay

Post-edge-detection stage between the Sobel processor and the DVI encoder in the digit-recognition video path. Each pixel of the Sobel magnitude stream is binarized against a threshold. The block tracks the bounding box of all foreground pixels in a frame and latches it at frame end. It outputs 24-bit RGB with the previous frame's box drawn as a coloured rectangle over the binary image. The latched box coordinates are also exported for the downstream digit-crop/classifier logic.

## Interface
Parameters:
- H_ACTIVE, 1280: active pixels per line.
- V_ACTIVE, 720: active lines per frame.
- THRESHOLD, 8'd32: foreground when in_data ≥ THRESHOLD.
- MIN_PIXELS, 20'd64: minimum foreground count for a box to be valid.
- BOX_COLOR, 24'hFF0000: overlay colour as {R,G,B}.
- SYNC_ACTIVE, 1'b1: active level of in_hs and in_vs.

Ports:
- clk in 1: pixel clock (74.25 MHz).
- rst_n in 1: asynchronous reset, active-low.
- in_de in 1: data enable, aligned with in_data.
- in_hs in 1: horizontal sync.
- in_vs in 1: vertical sync.
- in_data in 8: Sobel magnitude.
- out_de, out_hs, out_vs out 1 each: input timing delayed 2 cycles.
- out_r, out_g, out_b out 8 each: overlaid pixel.
- box_x0, box_x1 out 12 each: latched left/right column, inclusive.
- box_y0, box_y1 out 12 each: latched top/bottom line, inclusive.
- box_valid out 1: latched box meets MIN_PIXELS.
- box_stb out 1: one-cycle pulse when the box outputs update.

## Operation
- Position counters: x increments on each in_de=1 cycle and clears on the cycle after in_de falls. y increments on each in_de falling edge. Both clear on the vsync leading edge (transition to SYNC_ACTIVE). x saturates at H_ACTIVE-1 and y saturates at V_ACTIVE-1.
- fg = in_de & (in_data ≥ THRESHOLD).
- Per-frame accumulators:
  - min_x/min_y reset to all-ones; max_x/max_y reset to 0.
  - cnt is 20 bits, saturating.
  - On each fg pixel, update min/max with x/y and increment cnt.
- State machine:
  - IDLE: after reset, wait for the first vsync leading edge, then go to ACCUM.
  - ACCUM: accumulate. On the next vsync leading edge go to LATCH.
  - LATCH (1 cycle):
    - box_* ← accumulators.
    - box_valid ← (cnt ≥ MIN_PIXELS).
    - box_stb=1.
    - Accumulators reset.
    - Then go to ACCUM.
- Empty frame (cnt=0): box_valid=0 and box coordinates latch as 0.
- Overlay rule: pixel (x,y) is on the border when box_valid and either:
  - (x==box_x0 | x==box_x1) & box_y0≤y≤box_y1, or
  - (y==box_y0 | y==box_y1) & box_x0≤x≤box_x1.
- Output pixel, when out_de=1:
  - on border: BOX_COLOR;
  - otherwise fg: 24'hFFFFFF;
  - otherwise: 0.
- Output pixel is 0 whenever out_de=0.
- The overlay always uses the box latched from the previous frame; it never changes mid-frame.

## Timing
- Stage 1 registers timing, data, fg, x and y. Stage 2 performs the border compare and colour mux. Video latency is exactly 2 clk cycles for de/hs/vs/rgb.
- box_stb is asserted in the cycle after the clk edge that samples the vsync leading edge. box_* change in that same cycle.
- A pixel with in_de=1 in the same cycle as the vsync leading edge counts toward the closing frame.
- Reset values:
  - All outputs 0, except out_hs/out_vs, which reset to ~SYNC_ACTIVE.
  - State machine in IDLE; accumulators at their reset values.
- Reset asserted mid-frame: everything clears asynchronously. The partial frame after release is discarded, because IDLE waits for the next vsync edge, and no box_stb is issued for it.
- Overlay compares are registered in stage 2; there is no combinational path from in_* to out_*.

## Structure
- Shared package `video_pkg` holds:
  - XY_W=12 and CNT_W=20;
  - the state encoding (IDLE, ACCUM, LATCH);
  - COLOR_WHITE and COLOR_BLACK constants.
- One sub-module: `video_xy_counter`. It contains the edge detection on in_de/in_vs and the saturating x/y counters, and outputs x, y, sof (vsync leading edge) and eol.
- Top module contains the accumulators, the state machine, the latch registers and the two-stage overlay pipeline.

## Test plan
- **Reset and IDLE discard:** hold rst_n=0, then release mid-frame with fg pixels. All outputs stay 0 and there is no box_stb until the first vsync edge. That first edge starts accumulation but latches nothing.
- **Single blob:** a 1280×720 frame with in_data=200 in region x 100..149, y 50..89 (2000 pixels), 0 elsewhere. At the next vsync: box_stb pulse; box = (100,149,50,89); box_valid=1.
- **Overlay:** in the following frame, pixel (100,60) outputs FF0000, (120,60) outputs FFFFFF if fg, and (99,60) outputs 000000. All out_* lag in_* by exactly 2 cycles.
- **Below MIN_PIXELS:** a frame with 10 fg pixels yields box_valid=0 and no overlay in the next frame. An all-zero frame yields box = 0,0,0,0 and box_valid=0.
- **Threshold edge:** in_data=31 is treated as background and in_data=32 as foreground, with THRESHOLD=32.
- **Reset mid-ACCUM:** pulse rst_n low at line 300. box_* clear to 0. The next box_stb occurs only after two vsync edges.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the binarize / bounding-box / overlay video stage.
package video_pkg;

   localparam int unsigned XY_W  = 12;
   localparam int unsigned CNT_W = 20;
   localparam int unsigned RGB_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_LATCH = 2'd2
   } state_e;

   localparam logic [RGB_W-1:0] COLOR_WHITE = 24'hFFFFFF;
   localparam logic [RGB_W-1:0] COLOR_BLACK = 24'h000000;

   // Inclusive bounding box, columns then lines.
   typedef struct packed {
      logic [XY_W-1:0] x0;
      logic [XY_W-1:0] x1;
      logic [XY_W-1:0] y0;
      logic [XY_W-1:0] y1;
   } box_t;

   function automatic logic in_span(input logic [XY_W-1:0] v,
                                    input logic [XY_W-1:0] lo,
                                    input logic [XY_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/video_xy_counter.sv
// Pixel position tracker: de/vsync edge detection and saturating x/y counters.
// x_o/y_o give the position of the pixel currently presented on the input.
module video_xy_counter
   import video_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = 1280,
   parameter int unsigned V_ACTIVE    = 720,
   parameter logic        SYNC_ACTIVE = 1'b1
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            de_i,
   input  logic            vs_i,
   output logic [XY_W-1:0] x_o,
   output logic [XY_W-1:0] y_o,
   output logic            sof_c_o,
   output logic            eol_c_o
);

   localparam logic [XY_W-1:0] X_MAX = XY_W'(H_ACTIVE - 1);
   localparam logic [XY_W-1:0] Y_MAX = XY_W'(V_ACTIVE - 1);

   logic            de_q;
   logic            vs_q;
   logic [XY_W-1:0] x_q, x_d;
   logic [XY_W-1:0] y_q, y_d;

   assign sof_c_o = (vs_i == SYNC_ACTIVE) && (vs_q != SYNC_ACTIVE);
   assign eol_c_o = de_q && !de_i;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (sof_c_o) begin
         x_d = '0;
         y_d = '0;
      end else begin
         if (de_i) begin
            if (x_q != X_MAX) x_d = x_q + XY_W'(1);
         end else if (eol_c_o) begin
            x_d = '0;
         end
         if (eol_c_o && (y_q != Y_MAX)) y_d = y_q + XY_W'(1);
      end
   end

   // vs_q resets to the active level so a reset released mid-vsync cannot fake an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_q <= 1'b0;
         vs_q <= SYNC_ACTIVE;
         x_q  <= '0;
         y_q  <= '0;
      end else begin
         de_q <= de_i;
         vs_q <= vs_i;
         x_q  <= x_d;
         y_q  <= y_d;
      end
   end

   assign x_o = x_q;
   assign y_o = y_q;

endmodule

// File: rtl/bin_bbox_overlay.sv
// Binarizes the Sobel magnitude stream, tracks the per-frame foreground bounding box
// and draws the previous frame's box over the binary image (2-cycle video latency).
module bin_bbox_overlay
   import video_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = 1280,
   parameter int unsigned V_ACTIVE    = 720,
   parameter logic [7:0]  THRESHOLD   = 8'd32,
   parameter logic [19:0] MIN_PIXELS  = 20'd64,
   parameter logic [23:0] BOX_COLOR   = 24'hFF0000,
   parameter logic        SYNC_ACTIVE = 1'b1
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_de,
   input  logic            in_hs,
   input  logic            in_vs,
   input  logic [7:0]      in_data,
   output logic            out_de,
   output logic            out_hs,
   output logic            out_vs,
   output logic [7:0]      out_r,
   output logic [7:0]      out_g,
   output logic [7:0]      out_b,
   output logic [XY_W-1:0] box_x0,
   output logic [XY_W-1:0] box_x1,
   output logic [XY_W-1:0] box_y0,
   output logic [XY_W-1:0] box_y1,
   output logic            box_valid,
   output logic            box_stb
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [XY_W-1:0]  XY_ONES = '1;

   logic [XY_W-1:0] pix_x, pix_y;
   logic            sof_c;
   logic            unused_eol_c;
   logic            fg_c;

   video_xy_counter #(
      .H_ACTIVE    (H_ACTIVE),
      .V_ACTIVE    (V_ACTIVE),
      .SYNC_ACTIVE (SYNC_ACTIVE)
   ) u_xy (
      .clk     (clk),
      .rst_n   (rst_n),
      .de_i    (in_de),
      .vs_i    (in_vs),
      .x_o     (pix_x),
      .y_o     (pix_y),
      .sof_c_o (sof_c),
      .eol_c_o (unused_eol_c)
   );

   assign fg_c = in_de && (in_data >= THRESHOLD);

   state_e           state_q;
   logic [XY_W-1:0]  min_x_q, min_x_d, max_x_q, max_x_d;
   logic [XY_W-1:0]  min_y_q, min_y_d, max_y_q, max_y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   box_t             box_q, close_box_c;
   logic             box_valid_q;
   logic             box_stb_q;

   // Accumulators including the current pixel, so a pixel coincident with sof still counts.
   always_comb begin
      min_x_d = min_x_q;
      max_x_d = max_x_q;
      min_y_d = min_y_q;
      max_y_d = max_y_q;
      cnt_d   = cnt_q;
      if (fg_c) begin
         if (pix_x < min_x_q) min_x_d = pix_x;
         if (pix_x > max_x_q) max_x_d = pix_x;
         if (pix_y < min_y_q) min_y_d = pix_y;
         if (pix_y > max_y_q) max_y_d = pix_y;
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // An empty frame reports a zero box rather than the all-ones minimum.
   always_comb begin
      close_box_c = '0;
      if (cnt_d != '0) begin
         close_box_c.x0 = min_x_d;
         close_box_c.x1 = max_x_d;
         close_box_c.y0 = min_y_d;
         close_box_c.y1 = max_y_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         min_x_q     <= XY_ONES;
         max_x_q     <= '0;
         min_y_q     <= XY_ONES;
         max_y_q     <= '0;
         cnt_q       <= '0;
         box_q       <= '0;
         box_valid_q <= 1'b0;
         box_stb_q   <= 1'b0;
      end else begin
         box_stb_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (sof_c) state_q <= ST_ACCUM;
            end
            ST_ACCUM: begin
               if (sof_c) begin
                  state_q     <= ST_LATCH;
                  box_q       <= close_box_c;
                  box_valid_q <= (cnt_d >= MIN_PIXELS);
                  box_stb_q   <= 1'b1;
                  min_x_q     <= XY_ONES;
                  max_x_q     <= '0;
                  min_y_q     <= XY_ONES;
                  max_y_q     <= '0;
                  cnt_q       <= '0;
               end else begin
                  min_x_q <= min_x_d;
                  max_x_q <= max_x_d;
                  min_y_q <= min_y_d;
                  max_y_q <= max_y_d;
                  cnt_q   <= cnt_d;
               end
            end
            ST_LATCH: begin
               state_q <= ST_ACCUM;
               min_x_q <= min_x_d;
               max_x_q <= max_x_d;
               min_y_q <= min_y_d;
               max_y_q <= max_y_d;
               cnt_q   <= cnt_d;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   logic            s1_de_q, s1_hs_q, s1_vs_q, s1_fg_q;
   logic [XY_W-1:0] s1_x_q, s1_y_q;

   // Stage 1: timing, binarized pixel and its position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_de_q <= 1'b0;
         s1_hs_q <= ~SYNC_ACTIVE;
         s1_vs_q <= ~SYNC_ACTIVE;
         s1_fg_q <= 1'b0;
         s1_x_q  <= '0;
         s1_y_q  <= '0;
      end else begin
         s1_de_q <= in_de;
         s1_hs_q <= in_hs;
         s1_vs_q <= in_vs;
         s1_fg_q <= fg_c;
         s1_x_q  <= pix_x;
         s1_y_q  <= pix_y;
      end
   end

   logic              on_border_c;
   logic [RGB_W-1:0]  pix_rgb_c;

   always_comb begin
      on_border_c = 1'b0;
      if (box_valid_q) begin
         on_border_c =
            (((s1_x_q == box_q.x0) || (s1_x_q == box_q.x1)) &&
             in_span(s1_y_q, box_q.y0, box_q.y1)) ||
            (((s1_y_q == box_q.y0) || (s1_y_q == box_q.y1)) &&
             in_span(s1_x_q, box_q.x0, box_q.x1));
      end
      pix_rgb_c = COLOR_BLACK;
      if (s1_de_q) begin
         if (on_border_c)  pix_rgb_c = BOX_COLOR;
         else if (s1_fg_q) pix_rgb_c = COLOR_WHITE;
      end
   end

   logic             out_de_q, out_hs_q, out_vs_q;
   logic [RGB_W-1:0] out_rgb_q;

   // Stage 2: registered overlay result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_de_q  <= 1'b0;
         out_hs_q  <= ~SYNC_ACTIVE;
         out_vs_q  <= ~SYNC_ACTIVE;
         out_rgb_q <= '0;
      end else begin
         out_de_q  <= s1_de_q;
         out_hs_q  <= s1_hs_q;
         out_vs_q  <= s1_vs_q;
         out_rgb_q <= pix_rgb_c;
      end
   end

   assign out_de    = out_de_q;
   assign out_hs    = out_hs_q;
   assign out_vs    = out_vs_q;
   assign out_r     = out_rgb_q[23:16];
   assign out_g     = out_rgb_q[15:8];
   assign out_b     = out_rgb_q[7:0];
   assign box_x0    = box_q.x0;
   assign box_x1    = box_q.x1;
   assign box_y0    = box_q.y0;
   assign box_y1    = box_q.y1;
   assign box_valid = box_valid_q;
   assign box_stb   = box_stb_q;

endmodule

// File: tb/tb_bin_bbox_overlay.sv
// Directed bench for bin_bbox_overlay on a reduced 40x24 raster.
module tb_bin_bbox_overlay;
   import video_pkg::*;

   localparam int unsigned H = 40;
   localparam int unsigned V = 24;

   logic            clk;
   logic            rst_n;
   logic            in_de, in_hs, in_vs;
   logic [7:0]      in_data;
   logic            out_de, out_hs, out_vs;
   logic [7:0]      out_r, out_g, out_b;
   logic [XY_W-1:0] box_x0, box_x1, box_y0, box_y1;
   logic            box_valid, box_stb;

   bin_bbox_overlay #(
      .H_ACTIVE    (H),
      .V_ACTIVE    (V),
      .THRESHOLD   (8'd32),
      .MIN_PIXELS  (20'd64),
      .BOX_COLOR   (24'hFF0000),
      .SYNC_ACTIVE (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_de     (in_de),
      .in_hs     (in_hs),
      .in_vs     (in_vs),
      .in_data   (in_data),
      .out_de    (out_de),
      .out_hs    (out_hs),
      .out_vs    (out_vs),
      .out_r     (out_r),
      .out_g     (out_g),
      .out_b     (out_b),
      .box_x0    (box_x0),
      .box_x1    (box_x1),
      .box_y0    (box_y0),
      .box_y1    (box_y1),
      .box_valid (box_valid),
      .box_stb   (box_stb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic        chk;
      logic [23:0] rgb;
   } hent_t;

   hent_t       h0, h1;
   int          n_assert = 0;
   int          n_fail   = 0;
   int          stb_cnt  = 0;
   int          exp_stb  = 0;
   int          px [8];
   int          py [8];
   logic [23:0] prgb [8];
   int          np = 0;

   always @(posedge clk) if (box_stb === 1'b1) stb_cnt <= stb_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int mode, input int x, input int y);
      logic [7:0] v;
      v = 8'd0;
      case (mode)
         1: if (x >= 10 && x <= 19 && y >= 5 && y <= 12) v = 8'd200;
         2: if (y == 3 && x >= 20 && x <= 29) v = 8'd200;
         3: begin
            if (y == 7 && x == 5)  v = 8'd31;
            if (y == 7 && x == 6)  v = 8'd32;
            if (y == 20 && x == 30) v = 8'd31;
         end
         4: if (y == 2 && x >= 35) v = 8'd255;
         5: if (x <= 7 && y <= 7) v = 8'd200;
         6: if (x <= 7 && y <= 7 && !(x == 7 && y == 7)) v = 8'd200;
         default: v = 8'd0;
      endcase
      return v;
   endfunction

   // One clock: check the outputs of the pixel driven two steps ago, then drive a new one.
   task automatic step(input logic de, input logic hs, input logic vs, input logic [7:0] d,
                       input logic pchk, input logic [23:0] prgb_e);
      @(posedge clk);
      #1;
      if (!rst_n) h1 = '0;
      chk("out_de", 32'(out_de), 32'(h1.de));
      chk("out_hs", 32'(out_hs), 32'(h1.hs));
      chk("out_vs", 32'(out_vs), 32'(h1.vs));
      if (!h1.de)
         chk("rgb_blank", 32'({out_r, out_g, out_b}), 32'h0);
      else if (h1.chk)
         chk("rgb_pixel", 32'({out_r, out_g, out_b}), 32'(h1.rgb));
      h1 = rst_n ? h0 : '0;
      h0 = '{de: de, hs: hs, vs: vs, chk: pchk, rgb: prgb_e};
      in_de   = de;
      in_hs   = hs;
      in_vs   = vs;
      in_data = d;
   endtask

   task automatic send_lines(input int mode, input int width, input int y0, input int y1);
      for (int y = y0; y <= y1; y++) begin
         for (int x = 0; x < width; x++) begin
            logic        c;
            logic [23:0] e;
            c = 1'b0;
            e = 24'h0;
            for (int k = 0; k < np; k++)
               if (px[k] == x && py[k] == y) begin
                  c = 1'b1;
                  e = prgb[k];
               end
            step(1'b1, 1'b0, 1'b0, pix(mode, x, y), c, e);
         end
         for (int i = 0; i < 6; i++)
            step(1'b0, (i == 2 || i == 3), 1'b0, 8'd0, 1'b0, 24'h0);
      end
   endtask

   task automatic send_frame(input int mode, input int width);
      send_lines(mode, width, 0, int'(V) - 1);
   endtask

   task automatic vsync(input bit latch);
      step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 24'h0);
      step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 24'h0);
      step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 24'h0);
      chk("box_stb_pulse", 32'(box_stb), 32'(latch));
      step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 24'h0);
      chk("box_stb_width", 32'(box_stb), 32'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 24'h0);
      if (latch) exp_stb++;
      chk("box_stb_count", 32'(stb_cnt), 32'(exp_stb));
   endtask

   task automatic chk_box(input int x0, input int x1, input int y0, input int y1, input int v);
      chk("box_x0", 32'(box_x0), 32'(x0));
      chk("box_x1", 32'(box_x1), 32'(x1));
      chk("box_y0", 32'(box_y0), 32'(y0));
      chk("box_y1", 32'(box_y1), 32'(y1));
      chk("box_valid", 32'(box_valid), 32'(v));
   endtask

   task automatic add_probe(input int x, input int y, input logic [23:0] c);
      px[np]   = x;
      py[np]   = y;
      prgb[np] = c;
      np++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      in_de   = 1'b0;
      in_hs   = 1'b0;
      in_vs   = 1'b0;
      in_data = 8'd0;
      h0      = '0;
      h1      = '0;

      // Reset held with foreground pixels on the input, released mid-frame.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'd200, 1'b0, 24'h0);
      chk_box(0, 0, 0, 0, 0);
      chk("box_stb_reset", 32'(box_stb), 32'h0);
      rst_n = 1'b1;
      send_lines(1, int'(H), 6, int'(V) - 1);
      chk_box(0, 0, 0, 0, 0);
      chk("idle_no_stb", 32'(stb_cnt), 32'h0);
      vsync(1'b0);
      chk_box(0, 0, 0, 0, 0);

      // Single blob.
      send_frame(1, int'(H));
      vsync(1'b1);
      chk_box(10, 19, 5, 12, 1);

      // Overlay of the blob box on the next frame.
      add_probe(10, 8,  24'hFF0000);
      add_probe(12, 8,  24'hFFFFFF);
      add_probe(9,  8,  24'h000000);
      add_probe(19, 5,  24'hFF0000);
      add_probe(15, 12, 24'hFF0000);
      add_probe(10, 4,  24'h000000);
      add_probe(20, 12, 24'h000000);
      add_probe(15, 13, 24'h000000);
      send_frame(1, int'(H));
      np = 0;
      vsync(1'b1);
      chk_box(10, 19, 5, 12, 1);

      // Ten foreground pixels: coordinates latch, box not valid.
      send_frame(2, int'(H));
      vsync(1'b1);
      chk_box(20, 29, 3, 3, 0);

      // Invalid box draws nothing.
      add_probe(10, 8, 24'hFFFFFF);
      add_probe(20, 3, 24'h000000);
      add_probe(19, 5, 24'hFFFFFF);
      send_frame(1, int'(H));
      np = 0;
      vsync(1'b1);
      chk_box(10, 19, 5, 12, 1);

      // Empty frame.
      send_frame(0, int'(H));
      vsync(1'b1);
      chk_box(0, 0, 0, 0, 0);

      // Threshold edge: 31 is background, 32 is foreground.
      add_probe(0,  0,  24'h000000);
      add_probe(5,  7,  24'h000000);
      add_probe(6,  7,  24'hFFFFFF);
      add_probe(30, 20, 24'h000000);
      send_frame(3, int'(H));
      np = 0;
      vsync(1'b1);
      chk_box(6, 6, 7, 7, 0);

      // Exactly MIN_PIXELS foreground pixels, box touching the origin.
      send_frame(5, int'(H));
      vsync(1'b1);
      chk_box(0, 7, 0, 7, 1);

      // One short of MIN_PIXELS, overlaid with the previous valid box.
      add_probe(0, 0, 24'hFF0000);
      add_probe(7, 7, 24'hFF0000);
      add_probe(3, 3, 24'hFFFFFF);
      add_probe(8, 3, 24'h000000);
      send_frame(6, int'(H));
      np = 0;
      vsync(1'b1);
      chk_box(0, 7, 0, 7, 0);

      // Over-long lines: x saturates at H-1.
      send_frame(4, 50);
      vsync(1'b1);
      chk_box(35, 39, 2, 2, 0);

      // Reset mid-accumulation.
      send_lines(1, int'(H), 0, 8);
      rst_n = 1'b0;
      #1;
      chk_box(0, 0, 0, 0, 0);
      chk("box_stb_midrst", 32'(box_stb), 32'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 24'h0);
      rst_n = 1'b1;
      send_lines(1, int'(H), 9, int'(V) - 1);
      chk("midrst_no_stb", 32'(stb_cnt), 32'(exp_stb));
      vsync(1'b0);
      chk_box(0, 0, 0, 0, 0);
      send_frame(5, int'(H));
      vsync(1'b1);
      chk_box(0, 7, 0, 7, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
